back_rom_client: RTL and testbench

BACK_ROM_CLIENT -- requirements
Module: back_rom_client

---
 rtl/back_rom_client.sv | 124 ++++++++++++
 tb/tb_back_rom_client.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/back_rom_client.sv
// Background ROM client: camera-scrolled display fetch on port A and a
// three-state collision query engine on port B, sharing one clock.
module back_rom_client #(
  parameter int          ADDR_W      = 18,
  parameter int          SCALE_SHIFT = 1,
  parameter logic [3:0]  BLOCK_IDX   = 4'hF
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              de,
  input  logic              hs,
  input  logic              vs,
  input  logic [8:0]        cam_x_in,
  input  logic [8:0]        cam_y_in,
  output logic [ADDR_W-1:0] rom_address_a,
  input  logic [3:0]        rom_q_a,
  output logic [ADDR_W-1:0] rom_address_b,
  input  logic [3:0]        rom_q_b,
  output logic [3:0]        pix_idx,
  output logic              pix_de,
  output logic              pix_hs,
  output logic              pix_vs,
  input  logic              q_valid,
  input  logic [8:0]        q_x,
  input  logic [8:0]        q_y,
  output logic              q_ready,
  output logic              r_valid,
  output logic [3:0]        r_tile,
  output logic              r_block
);

  typedef enum logic [1:0] {IDLE, READ, RESP} q_state_t;

  logic [8:0] cam_x_reg, cam_y_reg;
  logic       vs_prev_reg;
  logic [8:0] map_x, map_y;
  logic       de_d1_reg, hs_d1_reg, vs_d1_reg;

  q_state_t   state_reg, state_next;
  logic       q_ready_next;
  logic       accept;
  logic       capture;

  // Map coordinates wrap independently in 9 bits; no carry between fields.
  assign map_x = cam_x_reg + 9'(drawX >> SCALE_SHIFT);
  assign map_y = cam_y_reg + 9'(drawY >> SCALE_SHIFT);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cam_x_reg     <= '0;
      cam_y_reg     <= '0;
      vs_prev_reg   <= 1'b1;
      rom_address_a <= '0;
      de_d1_reg     <= 1'b0;
      hs_d1_reg     <= 1'b1;
      vs_d1_reg     <= 1'b1;
      pix_idx       <= '0;
      pix_de        <= 1'b0;
      pix_hs        <= 1'b1;
      pix_vs        <= 1'b1;
    end else begin
      vs_prev_reg <= vs;
      // Camera only moves at the start of vertical sync release.
      if (vs && !vs_prev_reg) begin
        cam_x_reg <= cam_x_in;
        cam_y_reg <= cam_y_in;
      end
      rom_address_a <= ADDR_W'({map_y, map_x});
      de_d1_reg     <= de;
      hs_d1_reg     <= hs;
      vs_d1_reg     <= vs;
      pix_idx       <= de_d1_reg ? rom_q_a : 4'h0;
      pix_de        <= de_d1_reg;
      pix_hs        <= hs_d1_reg;
      pix_vs        <= vs_d1_reg;
    end
  end

  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (q_valid && q_ready) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    q_ready_next = (state_next == IDLE);
  end

  // q_ready is registered so it stays low through the reset cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      q_ready       <= 1'b0;
      rom_address_b <= '0;
      r_tile        <= '0;
      r_block       <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_ready   <= q_ready_next;
      if (accept)
        rom_address_b <= ADDR_W'({q_y, q_x});
      if (capture) begin
        r_tile  <= rom_q_b;
        r_block <= (rom_q_b == BLOCK_IDX);
      end
    end
  end

  assign r_valid = (state_reg == RESP);

endmodule

// File: tb/tb_back_rom_client.sv
// Bench for back_rom_client: directed scenarios then randomized traffic,
// every cycle compared against a frame/query-level reference model.
module tb_back_rom_client;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY;
  logic        de, hs, vs;
  logic [8:0]  cam_x_in, cam_y_in;
  logic [17:0] rom_address_a, rom_address_b;
  logic [3:0]  rom_q_a, rom_q_b;
  logic [3:0]  pix_idx;
  logic        pix_de, pix_hs, pix_vs;
  logic        q_valid;
  logic [8:0]  q_x, q_y;
  logic        q_ready, r_valid;
  logic [3:0]  r_tile;
  logic        r_block;

  logic [3:0]  rom_mem [0:262143];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0]  cam_x_m, cam_y_m;
  logic        vs_prev_m;
  logic        s1_de, s1_hs, s1_vs;
  logic [17:0] s1_addr;
  logic [17:0] exp_addr_a, exp_addr_b;
  logic [3:0]  exp_idx, exp_tile;
  logic        exp_de, exp_hs, exp_vs, exp_block, exp_ready, exp_rvalid;
  int          since_acc;
  logic        last_acc;

  always #5 vga_clk = ~vga_clk;

  assign rom_q_a = rom_mem[rom_address_a];
  assign rom_q_b = rom_mem[rom_address_b];

  back_rom_client dut (
    .vga_clk(vga_clk), .reset(reset),
    .drawX(drawX), .drawY(drawY), .de(de), .hs(hs), .vs(vs),
    .cam_x_in(cam_x_in), .cam_y_in(cam_y_in),
    .rom_address_a(rom_address_a), .rom_q_a(rom_q_a),
    .rom_address_b(rom_address_b), .rom_q_b(rom_q_b),
    .pix_idx(pix_idx), .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .q_valid(q_valid), .q_x(q_x), .q_y(q_y), .q_ready(q_ready),
    .r_valid(r_valid), .r_tile(r_tile), .r_block(r_block)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict, advance, then compare every output 1ns later.
  task automatic tick();
    int mx, my;
    logic acc;
    logic [17:0] a_now;
    mx = (int'(cam_x_m) + int'(drawX) / 2) % 512;
    my = (int'(cam_y_m) + int'(drawY) / 2) % 512;
    a_now = (18'(my) << 9) | 18'(mx);
    acc = q_valid && exp_ready && !reset;
    @(posedge vga_clk);
    #1;
    if (reset) begin
      cam_x_m = 9'd0; cam_y_m = 9'd0; vs_prev_m = 1'b1;
      s1_de = 1'b0; s1_hs = 1'b1; s1_vs = 1'b1; s1_addr = 18'd0;
      exp_addr_a = 18'd0; exp_idx = 4'd0;
      exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
      exp_addr_b = 18'd0; exp_tile = 4'd0; exp_block = 1'b0;
      exp_ready = 1'b0; exp_rvalid = 1'b0; since_acc = 100;
      acc = 1'b0;
    end else begin
      exp_idx = s1_de ? rom_mem[s1_addr] : 4'd0;
      exp_de = s1_de; exp_hs = s1_hs; exp_vs = s1_vs;
      s1_de = de; s1_hs = hs; s1_vs = vs; s1_addr = a_now;
      exp_addr_a = a_now;
      if (vs && !vs_prev_m) begin
        cam_x_m = cam_x_in;
        cam_y_m = cam_y_in;
      end
      vs_prev_m = vs;
      if (acc) begin
        exp_addr_b = {q_y, q_x};
        since_acc = 0;
      end else if (since_acc < 100) begin
        since_acc++;
      end
      if (since_acc == 1) begin
        exp_tile = rom_mem[exp_addr_b];
        exp_block = (exp_tile == 4'hF);
      end
      exp_ready = (since_acc >= 2);
      exp_rvalid = (since_acc == 1);
    end
    last_acc = acc;
    check("rom_address_a", 32'(rom_address_a), 32'(exp_addr_a));
    check("pix_idx", 32'(pix_idx), 32'(exp_idx));
    check("pix_de", 32'(pix_de), 32'(exp_de));
    check("pix_hs", 32'(pix_hs), 32'(exp_hs));
    check("pix_vs", 32'(pix_vs), 32'(exp_vs));
    check("rom_address_b", 32'(rom_address_b), 32'(exp_addr_b));
    check("q_ready", 32'(q_ready), 32'(exp_ready));
    check("r_valid", 32'(r_valid), 32'(exp_rvalid));
    check("r_tile", 32'(r_tile), 32'(exp_tile));
    check("r_block", 32'(r_block), 32'(exp_block));
    if (exp_rvalid)
      $display("query addr=%05h tile=%h block=%0d", exp_addr_b, exp_tile, exp_block);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) rom_mem[i] = 4'($urandom);
    exp_ready = 1'b0; last_acc = 1'b0; since_acc = 100;
    cam_x_m = 9'd0; cam_y_m = 9'd0; vs_prev_m = 1'b1;
    reset = 1'b1; drawX = 10'd0; drawY = 10'd0; de = 1'b0; hs = 1'b1; vs = 1'b1;
    cam_x_in = 9'd0; cam_y_in = 9'd0; q_valid = 1'b0; q_x = 9'd0; q_y = 9'd0;

    tick(); tick();
    check("reset_q_ready", 32'(q_ready), 32'd0);
    check("reset_pix_vs", 32'(pix_vs), 32'd1);
    reset = 1'b0;
    tick();
    check("release_q_ready", 32'(q_ready), 32'd1);

    // Basic fetch with camera at origin
    rom_mem[18'h00605] = 4'h7;
    drawX = 10'd10; drawY = 10'd6; de = 1'b1;
    tick();
    check("addr_a_basic", 32'(rom_address_a), 32'h00605);
    de = 1'b0;
    tick();
    check("pix_idx_basic", 32'(pix_idx), 32'h7);
    check("pix_de_basic", 32'(pix_de), 32'd1);

    // Camera load on vs rising, with 9-bit wrap
    vs = 1'b0; tick();
    cam_x_in = 9'd500; cam_y_in = 9'd510; vs = 1'b1; tick();
    drawX = 10'd40; drawY = 10'd10; de = 1'b1; tick();
    check("addr_a_wrap", 32'(rom_address_a), 32'h00608);
    cam_x_in = 9'd100; tick();
    check("addr_a_cam_hold", 32'(rom_address_a), 32'h00608);
    de = 1'b0;

    // Single query hitting a blocking tile
    rom_mem[18'h00403] = 4'hF;
    q_valid = 1'b1; q_x = 9'd3; q_y = 9'd2; tick();
    check("q_addr_b", 32'(rom_address_b), 32'h00403);
    check("q_busy", 32'(q_ready), 32'd0);
    q_valid = 1'b0; tick();
    check("q_rvalid", 32'(r_valid), 32'd1);
    check("q_tile", 32'(r_tile), 32'hF);
    check("q_block", 32'(r_block), 32'd1);
    tick();
    check("q_ready_back", 32'(q_ready), 32'd1);
    check("q_rvalid_drop", 32'(r_valid), 32'd0);

    // Back-to-back: second request raised during READ must not be lost
    q_valid = 1'b1; q_x = 9'd5; q_y = 9'd6; tick();
    q_x = 9'd7; q_y = 9'd8; tick();
    tick();
    tick();
    check("b2b_second_addr", 32'(rom_address_b), 32'h01007);
    q_valid = 1'b0; tick(); tick();

    // Reset right after accept aborts the query
    q_valid = 1'b1; q_x = 9'd1; q_y = 9'd1; tick();
    q_valid = 1'b0; reset = 1'b1; tick();
    check("abort_rvalid_rst", 32'(r_valid), 32'd0);
    reset = 1'b0; tick();
    check("abort_rvalid_rel", 32'(r_valid), 32'd0);
    check("abort_q_ready", 32'(q_ready), 32'd1);
    check("abort_pix_idx", 32'(pix_idx), 32'd0);
    check("abort_pix_de", 32'(pix_de), 32'd0);

    // Randomized traffic on both ports
    for (int n = 0; n < 3000; n++) begin
      drawX = 10'($urandom_range(0, 639));
      drawY = 10'($urandom_range(0, 479));
      de = ($urandom % 4) != 0;
      hs = ($urandom % 8) != 0;
      vs = ($urandom % 16) != 0;
      cam_x_in = 9'($urandom);
      cam_y_in = 9'($urandom);
      reset = ($urandom % 250) == 0;
      if (!q_valid || last_acc) begin
        q_valid = ($urandom % 3) == 0;
        q_x = 9'($urandom);
        q_y = 9'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
